// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(21,16) scrub controller.
package hamming_pkg;

    localparam int CW_W   = 21;
    localparam int DATA_W = 16;
    localparam int SYN_W  = 5;

    // Parity bits sit at power-of-two positions 1,2,4,8,16 (bit index = position-1)
    localparam int P1_IDX  = 0;
    localparam int P2_IDX  = 1;
    localparam int P4_IDX  = 3;
    localparam int P8_IDX  = 7;
    localparam int P16_IDX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHK  = 2'd1,
        WB   = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        KIND_HOST  = 1'b0,
        KIND_SCRUB = 1'b1
    } kind_t;

    // Pull the 16 payload bits out of a codeword (data positions only)
    function automatic logic [DATA_W-1:0] cw_payload(input logic [CW_W-1:0] cw);
        return {cw[2], cw[6:4], cw[14:8], cw[20:16]};
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome check and single-bit correction of one codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]   i_cw,
    output logic [SYN_W-1:0]  o_syn,
    output logic [CW_W-1:0]   o_cw,
    output logic [DATA_W-1:0] o_data,
    output logic              o_corr,
    output logic              o_uncorr
);

    // Syndrome bit k covers every position whose binary index has bit k set
    always_comb begin
        o_syn = '0;
        for (int p = 1; p <= CW_W; p++) begin
            for (int k = 0; k < SYN_W; k++) begin
                if (((p >> k) & 1) == 1) begin
                    o_syn[k] = o_syn[k] ^ i_cw[p-1];
                end
            end
        end
    end

    // Syndromes 1..21 name the flipped position; 22..31 cannot be a single error
    always_comb begin
        o_cw     = i_cw;
        o_corr   = 1'b0;
        o_uncorr = 1'b0;
        if (o_syn != '0) begin
            if (o_syn <= SYN_W'(CW_W)) begin
                o_corr = 1'b1;
                o_cw[o_syn - 5'd1] = ~i_cw[o_syn - 5'd1];
            end else begin
                o_uncorr = 1'b1;
            end
        end
    end

    assign o_data = cw_payload(o_cw);

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Single-port codeword memory owner: host reads vs. periodic background scrub,
// with one syndrome check per read and write-back of corrected single errors.
module hamming_scrub_ctrl
    import hamming_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_en,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_rsp_valid,
    input  logic              host_rsp_ready,
    output logic [15:0]       host_rsp_data,
    output logic              host_rsp_corr,
    output logic              host_rsp_uncorr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [20:0]       mem_rdata,
    output logic              mem_we,
    output logic [20:0]       mem_wdata,
    output logic [15:0]       corr_cnt,
    output logic [15:0]       uncorr_cnt,
    output logic [ADDR_W-1:0] last_err_addr,
    output logic              busy
);

    localparam int INT_W = $clog2(SCRUB_INTERVAL);

    state_t              r_state;
    state_t              w_next;
    kind_t               r_kind;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_scrub_ptr;
    logic [ADDR_W-1:0]   r_last_err;
    logic [INT_W-1:0]    r_int_cnt;
    logic                r_due;
    logic [CW_W-1:0]     r_cw;
    logic [DATA_W-1:0]   r_data;
    logic                r_corr;
    logic                r_uncorr;
    logic [15:0]         r_corr_cnt;
    logic [15:0]         r_uncorr_cnt;

    logic [SYN_W-1:0]    w_syn;
    logic [CW_W-1:0]     w_cw;
    logic [DATA_W-1:0]   w_data;
    logic                w_corr;
    logic                w_uncorr;
    logic                w_host_go;
    logic                w_scrub_go;
    logic                w_int_wrap;
    logic                w_ptr_adv;

    // mem_rdata is valid in CHK, one cycle after the IDLE read strobe
    hamming_syndrome u_syn (
        .i_cw     (mem_rdata),
        .o_syn    (w_syn),
        .o_cw     (w_cw),
        .o_data   (w_data),
        .o_corr   (w_corr),
        .o_uncorr (w_uncorr)
    );

    // Host always wins; a due scrub only issues on an otherwise idle cycle
    assign w_host_go  = (r_state == IDLE) && host_req_valid;
    assign w_scrub_go = (r_state == IDLE) && !host_req_valid && r_due;
    assign w_int_wrap = (r_int_cnt == INT_W'(SCRUB_INTERVAL - 1));
    assign w_ptr_adv  = (r_kind == KIND_SCRUB) &&
                        ((r_state == WB) || ((r_state == CHK) && !w_corr));

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (host_req_valid || r_due) w_next = CHK;
            CHK: begin
                if (w_corr)                  w_next = WB;
                else if (r_kind == KIND_HOST) w_next = RESP;
                else                         w_next = IDLE;
            end
            WB:   w_next = (r_kind == KIND_HOST) ? RESP : IDLE;
            RESP: if (host_rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Memory address mux: host/scrub address on issue, latched address on write-back
    always_comb begin
        mem_addr = '0;
        if (w_host_go)           mem_addr = host_addr;
        else if (w_scrub_go)     mem_addr = r_scrub_ptr;
        else if (r_state == WB)  mem_addr = r_addr;
    end

    assign mem_re          = w_host_go || w_scrub_go;
    assign mem_we          = (r_state == WB);
    assign mem_wdata       = (r_state == WB) ? r_cw : '0;
    assign host_req_ready  = (r_state == IDLE);
    assign host_rsp_valid  = (r_state == RESP);
    assign host_rsp_data   = (r_state == RESP) ? r_data : '0;
    assign host_rsp_corr   = (r_state == RESP) && r_corr;
    assign host_rsp_uncorr = (r_state == RESP) && r_uncorr;
    assign busy            = (r_state != IDLE);
    assign corr_cnt        = r_corr_cnt;
    assign uncorr_cnt      = r_uncorr_cnt;
    assign last_err_addr   = r_last_err;

    // FSM state and the transaction's address/kind captured at issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_kind  <= KIND_HOST;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_host_go) begin
                r_kind <= KIND_HOST;
                r_addr <= host_addr;
            end else if (w_scrub_go) begin
                r_kind <= KIND_SCRUB;
                r_addr <= r_scrub_ptr;
            end
        end
    end

    // Capture the check result and update error bookkeeping in CHK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cw         <= '0;
            r_data       <= '0;
            r_corr       <= 1'b0;
            r_uncorr     <= 1'b0;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
            r_last_err   <= '0;
        end else if (r_state == CHK) begin
            r_cw     <= w_cw;
            r_data   <= w_data;
            r_corr   <= w_corr;
            r_uncorr <= w_uncorr;
            if (w_syn != '0) r_last_err <= r_addr;
            if (w_corr && (r_corr_cnt != 16'hFFFF))
                r_corr_cnt <= r_corr_cnt + 16'd1;
            if (w_uncorr && (r_uncorr_cnt != 16'hFFFF))
                r_uncorr_cnt <= r_uncorr_cnt + 16'd1;
        end
    end

    // Scrub pointer steps once per completed scrub, wrapping at DEPTH-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scrub_ptr <= '0;
        end else if (w_ptr_adv) begin
            if (r_scrub_ptr == ADDR_W'(DEPTH - 1)) r_scrub_ptr <= '0;
            else                                   r_scrub_ptr <= r_scrub_ptr + ADDR_W'(1);
        end
    end

    // Interval timer and due flag; a fresh due beats a same-cycle issue so no tick is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_cnt <= '0;
            r_due     <= 1'b0;
        end else if (!scrub_en) begin
            r_int_cnt <= '0;
            r_due     <= 1'b0;
        end else if (w_int_wrap) begin
            r_int_cnt <= '0;
            r_due     <= 1'b1;
        end else begin
            r_int_cnt <= r_int_cnt + INT_W'(1);
            if (w_scrub_go) r_due <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Self-checking bench for hamming_scrub_ctrl: vector table, randomized reads
// against a position-XOR reference model, and hand-written scrub/reset sequences.
module tb_hamming_scrub_ctrl;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int SI     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              scrub_en;
    logic              host_req_valid;
    logic              host_req_ready;
    logic [ADDR_W-1:0] host_addr;
    logic              host_rsp_valid;
    logic              host_rsp_ready;
    logic [15:0]       host_rsp_data;
    logic              host_rsp_corr;
    logic              host_rsp_uncorr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [20:0]       mem_rdata;
    logic              mem_we;
    logic [20:0]       mem_wdata;
    logic [15:0]       corr_cnt;
    logic [15:0]       uncorr_cnt;
    logic [ADDR_W-1:0] last_err_addr;
    logic              busy;

    int n_checks = 0;
    int n_err    = 0;

    int          m_corr = 0;
    int          m_uncorr = 0;
    logic [7:0]  m_last = '0;

    logic [20:0] mem [0:255];
    logic        bd_we = 1'b0;
    logic        bd_clr = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [20:0] bd_data = '0;

    hamming_scrub_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI)) dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_addr(host_addr), .host_rsp_valid(host_rsp_valid),
        .host_rsp_ready(host_rsp_ready), .host_rsp_data(host_rsp_data),
        .host_rsp_corr(host_rsp_corr), .host_rsp_uncorr(host_rsp_uncorr),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt), .last_err_addr(last_err_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency plus a backdoor for loading words
    always @(posedge clk) begin
        if (bd_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // ---------------- reference model ----------------
    function automatic int ref_syn(input logic [20:0] cw);
        int s = 0;
        for (int p = 1; p <= 21; p++) if (cw[p-1]) s = s ^ p;
        return s;
    endfunction

    function automatic logic [20:0] ref_fix(input logic [20:0] cw);
        int s = ref_syn(cw);
        logic [20:0] r = cw;
        if (s >= 1 && s <= 21) r[s-1] = ~r[s-1];
        return r;
    endfunction

    function automatic logic [15:0] ref_payload(input logic [20:0] cw);
        return {cw[2], cw[6:4], cw[14:8], cw[20:16]};
    endfunction

    function automatic logic [20:0] ref_encode(input logic [15:0] d);
        logic [20:0] cw = '0;
        int s;
        cw[2]     = d[15];
        cw[6:4]   = d[14:12];
        cw[14:8]  = d[11:5];
        cw[20:16] = d[4:0];
        s = ref_syn(cw);
        for (int k = 0; k < 5; k++) cw[(1 << k) - 1] = s[k];
        return cw;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", nm, act, exp);
        end
    endtask

    task automatic chk_counters(input string nm);
        chk(nm, {corr_cnt, uncorr_cnt, last_err_addr},
            {m_corr[15:0], m_uncorr[15:0], m_last});
    endtask

    task automatic chk_quiet(input string nm);
        // ready is 1 because the controller sits in IDLE; everything else is 0
        chk({nm, "_a"}, {host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_corr,
                         host_rsp_uncorr, mem_addr, mem_re, mem_we, busy}, {1'b1, 30'd0});
        chk({nm, "_b"}, {mem_wdata, corr_cnt, uncorr_cnt, last_err_addr}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        scrub_en = 1'b0;
        host_req_valid = 1'b0;
        host_rsp_ready = 1'b0;
        host_addr = '0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        m_corr = 0; m_uncorr = 0; m_last = '0;
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [20:0] d);
        @(negedge clk);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic bd_clear();
        @(negedge clk);
        bd_clr = 1'b1;
        @(negedge clk);
        bd_clr = 1'b0;
    endtask

    // One host read: accept, wait for response (bounded), optional backpressure, handshake
    task automatic do_read(input logic [7:0] addr, input int rdy_delay,
                           output logic [15:0] d, output logic c, output logic u,
                           output int lat, output logic wb,
                           output logic [7:0] wba, output logic [20:0] wbd);
        d = '0; c = 1'b0; u = 1'b0; lat = 0; wb = 1'b0; wba = '0; wbd = '0;
        @(negedge clk);
        host_req_valid = 1'b1;
        host_addr = addr;
        #1;
        chk("accept", {host_req_ready, mem_re, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, addr});
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            host_req_valid = 1'b0;
            if (mem_we) begin
                wb = 1'b1; wba = mem_addr; wbd = mem_wdata;
                chk("re_we_excl", mem_re, 1'b0);
            end
            if (host_rsp_valid) lat = k;
        end
        if (lat == 0) begin
            chk("rsp_seen", host_rsp_valid, 1'b1);
        end else begin
            d = host_rsp_data; c = host_rsp_corr; u = host_rsp_uncorr;
            for (int k = 0; k < rdy_delay; k++) begin
                @(negedge clk);
                chk("rsp_hold", {host_rsp_valid, host_req_ready, host_rsp_data, host_rsp_corr,
                                 host_rsp_uncorr}, {1'b1, 1'b0, d, c, u});
            end
            host_rsp_ready = 1'b1;
            @(negedge clk);
            host_rsp_ready = 1'b0;
            chk("rsp_done", {busy, host_rsp_valid}, 2'b00);
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [20:0] cw;
        logic [15:0] data;
        logic        corr;
        logic        uncorr;
        int          lat;
        logic [20:0] fixed;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [15:0] d;
        logic        c, u, wb;
        int          lat;
        logic [7:0]  wba;
        logic [20:0] wbd;
        logic [7:0]  reads [5];
        int          nr, nwb;
        logic [7:0]  wb_a;
        logic [20:0] wb_d;

        tbl[0] = '{8'd5,  21'h000000, 16'h0000, 1'b0, 1'b0, 2, 21'h000000};
        tbl[1] = '{8'd7,  21'h000010, 16'h0000, 1'b1, 1'b0, 3, 21'h000000};
        tbl[2] = '{8'd9,  21'h100200, 16'h0050, 1'b0, 1'b1, 2, 21'h100200};
        tbl[3] = '{8'd11, 21'h000001, 16'h0000, 1'b1, 1'b0, 3, 21'h000000};
        tbl[4] = '{8'd12, 21'h000007, 16'h8000, 1'b0, 1'b0, 2, 21'h000007};
        tbl[5] = '{8'd13, 21'h000003, 16'h8000, 1'b1, 1'b0, 3, 21'h000007};
        tbl[6] = '{8'd14, 21'h008020, 16'h2000, 1'b0, 1'b1, 2, 21'h008020};
        tbl[7] = '{8'd15, 21'h1FFFFF, 16'hFFFF, 1'b1, 1'b0, 3, 21'h1FFFFE};

        do_reset();
        bd_clear();

        // ---- vector table ----
        foreach (tbl[i]) begin
            bd_write(tbl[i].addr, tbl[i].cw);
            do_read(tbl[i].addr, 0, d, c, u, lat, wb, wba, wbd);
            chk("tbl_rsp", {d, c, u}, {tbl[i].data, tbl[i].corr, tbl[i].uncorr});
            chk("tbl_lat", lat, tbl[i].lat);
            chk("tbl_wb", {wb, wba, wbd}, tbl[i].corr ? {1'b1, tbl[i].addr, tbl[i].fixed} : 30'd0);
            chk("tbl_mem", mem[tbl[i].addr], tbl[i].fixed);
            if (tbl[i].corr) m_corr++;
            if (tbl[i].uncorr) m_uncorr++;
            if (tbl[i].corr || tbl[i].uncorr) m_last = tbl[i].addr;
            chk_counters("tbl_cnt");
        end

        // ---- randomized reads against the model ----
        for (int it = 0; it < 40; it++) begin
            logic [7:0]  a;
            logic [20:0] cw, fx;
            int          s, mode, b1, b2;
            a = 8'($urandom_range(16, 255));
            mode = $urandom_range(0, 3);
            cw = ref_encode(16'($urandom));
            b1 = $urandom_range(0, 20);
            b2 = (b1 + $urandom_range(1, 20)) % 21;
            if (mode == 1) cw[b1] = ~cw[b1];
            if (mode == 2) begin cw[b1] = ~cw[b1]; cw[b2] = ~cw[b2]; end
            if (mode == 3) cw = 21'($urandom);
            s = ref_syn(cw);
            fx = ref_fix(cw);
            bd_write(a, cw);
            do_read(a, $urandom_range(0, 2), d, c, u, lat, wb, wba, wbd);
            chk("rnd_rsp", {d, c, u}, {ref_payload(fx), (s >= 1 && s <= 21), (s > 21)});
            chk("rnd_lat", lat, (s >= 1 && s <= 21) ? 3 : 2);
            chk("rnd_wb", {wb, wba, wbd}, (s >= 1 && s <= 21) ? {1'b1, a, fx} : 30'd0);
            if (s >= 1 && s <= 21) m_corr++;
            if (s > 21) m_uncorr++;
            if (s != 0) m_last = a;
            chk_counters("rnd_cnt");
        end

        // ---- arbitration: due scrub and host request collide ----
        do_reset();
        bd_clear();
        @(negedge clk);
        scrub_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_early_scrub", mem_re, 1'b0);
        end
        do_read(8'd20, 1, d, c, u, lat, wb, wba, wbd);
        chk("arb_host_rsp", {d, c, u, lat[3:0]}, {16'h0, 1'b0, 1'b0, 4'd2});
        #1;
        chk("arb_scrub_next", {mem_re, mem_addr}, {1'b1, 8'd0});
        @(negedge clk);
        chk("arb_scrub_chk", {busy, mem_re}, 2'b10);
        @(negedge clk);
        chk("due_cleared", {busy, mem_re}, 2'b00);
        @(negedge clk);
        chk("due_cleared2", mem_re, 1'b0);
        @(negedge clk);
        chk("next_scrub", {mem_re, mem_addr}, {1'b1, 8'd1});
        scrub_en = 1'b0;
        repeat (4) @(negedge clk);

        // ---- scrub wrap with DEPTH=4 and an error planted at 3 ----
        do_reset();
        bd_clear();
        bd_write(8'd3, 21'h000001);
        @(negedge clk);
        scrub_en = 1'b1;
        nr = 0; nwb = 0; wb_a = '0; wb_d = '0;
        for (int k = 0; k < 80 && nr < 5; k++) begin
            @(negedge clk);
            if (mem_re) begin reads[nr] = mem_addr; nr++; end
            if (mem_we) begin nwb++; wb_a = mem_addr; wb_d = mem_wdata; end
        end
        scrub_en = 1'b0;
        chk("wrap_nreads", nr, 5);
        if (nr == 5) chk("wrap_order", {reads[0], reads[1], reads[2], reads[3], reads[4]},
                         {8'd0, 8'd1, 8'd2, 8'd3, 8'd0});
        chk("wrap_wb", {nwb[3:0], wb_a, wb_d}, {4'd1, 8'd3, 21'h0});
        repeat (4) @(negedge clk);
        chk("wrap_mem3", mem[3], 21'h0);
        m_corr = 1; m_last = 8'd3;
        chk_counters("wrap_cnt");

        // ---- backpressure: response held for 10 cycles ----
        do_reset();
        bd_write(8'd7, 21'h000010);
        do_read(8'd7, 10, d, c, u, lat, wb, wba, wbd);
        chk("bp_rsp", {d, c, u, lat[3:0]}, {16'h0, 1'b1, 1'b0, 4'd3});

        // ---- reset asserted during write-back ----
        bd_write(8'd7, 21'h000010);
        @(negedge clk);
        host_req_valid = 1'b1;
        host_addr = 8'd7;
        @(negedge clk);
        host_req_valid = 1'b0;
        @(negedge clk);
        chk("wb_before_rst", {mem_we, mem_addr}, {1'b1, 8'd7});
        rst = 1'b1;
        #1;
        chk_quiet("rst_in_wb");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("wb_aborted", mem[7], 21'h000010);
        chk("rst_no_rsp", {busy, host_rsp_valid}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
